// File: rtl/float_multiplier_pipelined_if.sv
// Operand/result handshake bundle for float_multiplier_pipelined.
// W is the float word width (1 + EXP_W + MAN_W).
interface float_multiplier_pipelined_if #(
  parameter int W = 8
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_y;
  logic [3:0]   out_flags;

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_y, out_flags
  );

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_y, out_flags
  );
endinterface

// File: rtl/float_multiplier_pipelined.sv
// Float multiply with RNE rounding, subnormals and specials; FMUL_SATURATE_EN clamps overflow to max finite.
// Latency 3 cycles at 1/cycle; all stages hold together while out_valid && !out_ready, and in_ready drops.
module float_multiplier_pipelined #(
  parameter int EXP_W = 4,
  parameter int MAN_W = 3,
  parameter int BIAS  = 2**(EXP_W-1)-1
) (
  input logic clock,
  input logic rst_n,
  float_multiplier_pipelined_if.slave bus
);
  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int MW = MAN_W + 1;
  localparam int P  = 2 * MW;
  localparam int EW = EXP_W + 2;
  localparam logic [EXP_W-1:0]     EXP_ONES = '1;
  localparam logic signed [EW-1:0] E_ONE    = EW'(1);
  localparam logic signed [EW-1:0] E_MAX    = EW'(2**EXP_W - 1);
  localparam logic [EW-1:0]        BIAS_E   = EW'(BIAS);
  localparam logic [W-1:0]         QNAN     = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};

  logic adv;
  logic out_valid_q;
  logic [W-1:0] out_y_q;
  logic [3:0] out_flags_q;

  assign adv            = !out_valid_q || bus.out_ready;
  assign bus.in_ready   = adv;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_y      = out_y_q;
  assign bus.out_flags  = out_flags_q;

  // ---------------- S1: unpack, classify, multiply ----------------
  logic             sa, sb;
  logic [EXP_W-1:0] ea, eb, ea_eff, eb_eff;
  logic [MAN_W-1:0] fa, fb;
  logic [MW-1:0]    ma, mb;
  logic             a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic signed [EW-1:0] e_sum;
  logic [P-1:0]     prod;

  assign sa     = bus.in_a[W-1];
  assign sb     = bus.in_b[W-1];
  assign ea     = bus.in_a[W-2 -: EXP_W];
  assign eb     = bus.in_b[W-2 -: EXP_W];
  assign fa     = bus.in_a[MAN_W-1:0];
  assign fb     = bus.in_b[MAN_W-1:0];
  assign a_nan  = (ea == EXP_ONES) && (fa != '0);
  assign b_nan  = (eb == EXP_ONES) && (fb != '0);
  assign a_inf  = (ea == EXP_ONES) && (fa == '0);
  assign b_inf  = (eb == EXP_ONES) && (fb == '0);
  assign a_zero = (ea == '0) && (fa == '0);
  assign b_zero = (eb == '0) && (fb == '0);
  // Subnormals carry hidden bit 0 at the minimum effective exponent.
  assign ma     = {ea != '0, fa};
  assign mb     = {eb != '0, fb};
  assign ea_eff = (ea == '0) ? EXP_W'(1) : ea;
  assign eb_eff = (eb == '0) ? EXP_W'(1) : eb;
  assign e_sum  = {2'b00, ea_eff} + {2'b00, eb_eff} - BIAS_E;
  assign prod   = {{MW{1'b0}}, ma} * {{MW{1'b0}}, mb};

  logic         s1n_spec;
  logic [W-1:0] s1n_spec_y;
  logic [3:0]   s1n_spec_flags;

  always_comb begin
    s1n_spec       = 1'b0;
    s1n_spec_y     = '0;
    s1n_spec_flags = '0;
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
      s1n_spec       = 1'b1;
      s1n_spec_y     = QNAN;
      s1n_spec_flags = 4'b1000;
    end else if (a_inf || b_inf) begin
      s1n_spec   = 1'b1;
      s1n_spec_y = {sa ^ sb, EXP_ONES, {MAN_W{1'b0}}};
    end else if (a_zero || b_zero) begin
      s1n_spec   = 1'b1;
      s1n_spec_y = {sa ^ sb, {(W-1){1'b0}}};
    end
  end

  logic                 s1_vld, s1_sign, s1_spec;
  logic signed [EW-1:0] s1_e;
  logic [P-1:0]         s1_prod;
  logic [W-1:0]         s1_spec_y;
  logic [3:0]           s1_spec_flags;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld        <= 1'b0;
      s1_sign       <= 1'b0;
      s1_spec       <= 1'b0;
      s1_e          <= '0;
      s1_prod       <= '0;
      s1_spec_y     <= '0;
      s1_spec_flags <= '0;
    end else if (adv) begin
      s1_vld        <= bus.in_valid;
      s1_sign       <= sa ^ sb;
      s1_spec       <= s1n_spec;
      s1_e          <= e_sum;
      s1_prod       <= prod;
      s1_spec_y     <= s1n_spec_y;
      s1_spec_flags <= s1n_spec_flags;
    end
  end

  // ---------------- S2: normalise so the hidden bit sits at P-1 ----------------
  logic [P-1:0]         s2n_nm;
  logic signed [EW-1:0] s2n_e;
  logic                 s2n_sticky;

  always_comb begin
    s2n_nm     = s1_prod;
    s2n_e      = s1_e;
    s2n_sticky = 1'b0;
    if (s1_prod[P-1]) s2n_e = s1_e + E_ONE;
    else              s2n_nm = s1_prod << 1;
    for (int i = 0; i < P; i++) begin
      if (!s2n_nm[P-1] && (s2n_e > E_ONE)) begin
        s2n_nm = s2n_nm << 1;
        s2n_e  = s2n_e - E_ONE;
      end
    end
    // Below the normal range: denormalise, folding lost bits into sticky.
    if (s2n_e < E_ONE) begin
      for (int i = 0; i < P; i++) begin
        if (s2n_e < E_ONE) begin
          s2n_sticky = s2n_sticky | s2n_nm[0];
          s2n_nm     = s2n_nm >> 1;
          s2n_e      = s2n_e + E_ONE;
        end
      end
      s2n_e = E_ONE;
    end
  end

  logic                 s2_vld, s2_sign, s2_spec, s2_sticky;
  logic signed [EW-1:0] s2_e;
  logic [P-1:0]         s2_nm;
  logic [W-1:0]         s2_spec_y;
  logic [3:0]           s2_spec_flags;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      s2_vld        <= 1'b0;
      s2_sign       <= 1'b0;
      s2_spec       <= 1'b0;
      s2_sticky     <= 1'b0;
      s2_e          <= '0;
      s2_nm         <= '0;
      s2_spec_y     <= '0;
      s2_spec_flags <= '0;
    end else if (adv) begin
      s2_vld        <= s1_vld;
      s2_sign       <= s1_sign;
      s2_spec       <= s1_spec;
      s2_sticky     <= s2n_sticky;
      s2_e          <= s2n_e;
      s2_nm         <= s2n_nm;
      s2_spec_y     <= s1_spec_y;
      s2_spec_flags <= s1_spec_flags;
    end
  end

  // ---------------- S3: round to nearest even, pack, flag ----------------
  logic [MW-1:0]        mant;
  logic [MW:0]          sum;
  logic                 g, r, st, rnd, inexact, tiny, ovf, normal;
  logic signed [EW-1:0] e_r;
  logic [MAN_W-1:0]     man_r;
  logic [W-1:0]         s3n_y;
  logic [3:0]           s3n_flags;

  assign mant    = s2_nm[P-1 -: MW];
  assign g       = s2_nm[MAN_W];
  assign r       = s2_nm[MAN_W-1];
  assign st      = (|s2_nm[MAN_W-2:0]) | s2_sticky;
  assign rnd     = g & (r | st | mant[0]);
  assign sum     = {1'b0, mant} + {{MW{1'b0}}, rnd};
  assign e_r     = sum[MW] ? s2_e + E_ONE : s2_e;
  assign man_r   = sum[MW] ? sum[MAN_W:1] : sum[MAN_W-1:0];
  // A rounded-up subnormal reaching the hidden bit becomes normal with exponent 1.
  assign normal  = sum[MW] | sum[MAN_W];
  assign inexact = g | r | st;
  assign tiny    = !s2_nm[P-1];
  assign ovf     = e_r >= E_MAX;

  always_comb begin
    s3n_y     = {s2_sign, normal ? e_r[EXP_W-1:0] : {EXP_W{1'b0}}, man_r};
    s3n_flags = {2'b00, tiny & inexact, inexact};
    if (s2_spec) begin
      s3n_y     = s2_spec_y;
      s3n_flags = s2_spec_flags;
    end else if (ovf) begin
`ifdef FMUL_SATURATE_EN
      s3n_y = {s2_sign, {{(EXP_W-1){1'b1}}, 1'b0}, {MAN_W{1'b1}}};
`else
      s3n_y = {s2_sign, EXP_ONES, {MAN_W{1'b0}}};
`endif
      s3n_flags = 4'b0101;
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_y_q     <= '0;
      out_flags_q <= '0;
    end else if (adv) begin
      out_valid_q <= s2_vld;
      out_y_q     <= s3n_y;
      out_flags_q <= s3n_flags;
    end
  end
endmodule

// File: tb/tb_float_multiplier_pipelined.sv
// Bench for float_multiplier_pipelined at e4m3 (EXP_W=4, MAN_W=3, BIAS=7).
// Reference model rounds the exact integer product; expectation follows FMUL_SATURATE_EN.
module tb_float_multiplier_pipelined;
  logic clock = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  logic [11:0] exp_q[$];

  always #5 clock = ~clock;

  float_multiplier_pipelined_if #(.W(8)) bus ();

  float_multiplier_pipelined #(.EXP_W(4), .MAN_W(3), .BIAS(7)) dut (
    .clock (clock),
    .rst_n (rst_n),
    .bus   (bus)
  );

`ifdef FMUL_SATURATE_EN
  localparam logic [7:0] OVF_Y = 8'h77;
`else
  localparam logic [7:0] OVF_Y = 8'h78;
`endif
  localparam logic [7:0] DA [7] = '{8'h38, 8'h39, 8'h77, 8'h08, 8'h01, 8'h78, 8'hF8};
  localparam logic [7:0] DB [7] = '{8'h38, 8'h3C, 8'h77, 8'h30, 8'h01, 8'h00, 8'h38};
  localparam logic [7:0] DY [7] = '{8'h38, 8'h3E, OVF_Y, 8'h04, 8'h00, 8'h7C, 8'hF8};
  localparam logic [3:0] DF [7] = '{4'b0000, 4'b0001, 4'b0101, 4'b0000, 4'b0011, 4'b1000, 4'b0000};

  // Exact value of each operand is M * 2^X; round the integer product straight to the target grid.
  function automatic logic [11:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
    logic   s, inexact, tiny;
    int     ea, eb, fa, fb, x, q, ue, k, msb, expf;
    longint p, n, rem, half;
    logic [7:0] y;
    logic [3:0] f;
    s  = a[7] ^ b[7];
    ea = int'(a[6:3]); eb = int'(b[6:3]);
    fa = int'(a[2:0]); fb = int'(b[2:0]);
    if ((ea == 15 && fa != 0) || (eb == 15 && fb != 0) ||
        (ea == 15 && b[6:0] == 7'd0) || (eb == 15 && a[6:0] == 7'd0))
      return {8'h7C, 4'b1000};
    if (ea == 15 || eb == 15) return {s, 7'h78, 4'b0000};
    if (a[6:0] == 7'd0 || b[6:0] == 7'd0) return {s, 7'h00, 4'b0000};
    p = longint'(((ea == 0) ? fa : fa + 8) * ((eb == 0) ? fb : fb + 8));
    x = ((ea == 0) ? 1 : ea) - 10 + ((eb == 0) ? 1 : eb) - 10;
    msb = 0;
    for (int i = 0; i < 16; i++) if (p[i]) msb = i;
    q  = x + msb;
    ue = ((q > -6) ? q : -6) - 3;
    k  = ue - x;
    inexact = 1'b0;
    if (k <= 0) n = p <<< (-k);
    else begin
      n    = p >> k;
      rem  = p - (n << k);
      half = longint'(1) << (k - 1);
      inexact = (rem != 0);
      if (rem > half || (rem == half && n[0])) n = n + 1;
    end
    if (n == 16) begin n = 8; ue = ue + 1; end
    tiny = (q < -6);
    expf = (n < 8) ? 0 : ue + 10;
    if (expf >= 15) begin
      y = {s, OVF_Y[6:0]};
      f = 4'b0101;
    end else begin
      y = {s, expf[3:0], n[2:0]};
      f = {2'b00, tiny & inexact, inexact};
    end
    return {y, f};
  endfunction

  // One clock of stimulus; reports the handshakes that complete at the coming rising edge.
  task automatic cycle(input logic iv, input logic [7:0] a, input logic [7:0] b, input logic ordy,
                       output logic acc, output logic got, output logic [7:0] y, output logic [3:0] f);
    @(negedge clock);
    bus.in_valid  = iv;
    bus.in_a      = a;
    bus.in_b      = b;
    bus.out_ready = ordy;
    #1;
    acc = bus.in_valid & bus.in_ready;
    got = bus.out_valid & bus.out_ready;
    y   = bus.out_y;
    f   = bus.out_flags;
    if (acc) exp_q.push_back(ref_mul(a, b));
    cyc++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.out_ready = 1'b0;
    repeat (3) @(negedge clock);
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    n_checks++;
    if (bus.out_y !== 8'h00) begin n_fail++; $display("FAIL reset_out_y: got %h want 00", bus.out_y); end
    n_checks++;
    if (bus.out_flags !== 4'b0000) begin n_fail++; $display("FAIL reset_out_flags: got %b want 0000", bus.out_flags); end
    n_checks++;
    if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
  endtask

  task automatic test_directed();
    logic acc, got;
    logic [7:0] y;
    logic [3:0] f;
    int c0, n;
    for (int v = 0; v < 7; v++) begin
      n = 0; acc = 1'b0;
      while (!acc && n < 10) begin cycle(1'b1, DA[v], DB[v], 1'b1, acc, got, y, f); n++; end
      c0 = cyc;
      n = 0; got = 1'b0;
      while (!got && n < 10) begin cycle(1'b0, 8'h00, 8'h00, 1'b1, acc, got, y, f); n++; end
      n_checks++;
      if (!got) begin
        n_fail++; $display("FAIL dir%0d_timeout: no result within 10 cycles", v);
      end else begin
        n_checks++;
        if (y !== DY[v]) begin n_fail++; $display("FAIL dir%0d_y: %h*%h got %h want %h", v, DA[v], DB[v], y, DY[v]); end
        n_checks++;
        if (f !== DF[v]) begin n_fail++; $display("FAIL dir%0d_flags: %h*%h got %b want %b", v, DA[v], DB[v], f, DF[v]); end
        n_checks++;
        if (cyc - c0 != 3) begin n_fail++; $display("FAIL dir%0d_latency: got %0d want 3", v, cyc - c0); end
      end
      exp_q.delete();
    end
  endtask

  task automatic test_random();
    logic acc, got;
    logic [7:0] y;
    logic [3:0] f;
    logic [11:0] e;
    int n;
    exp_q.delete();
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom % 4) != 0, 8'($urandom), 8'($urandom), ($urandom % 4) != 0, acc, got, y, f);
      if (got) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL rand_extra: unexpected result %h", y);
        end else begin
          e = exp_q.pop_front();
          if ({y, f} !== e) begin n_fail++; $display("FAIL rand_result: got y=%h f=%b want y=%h f=%b", y, f, e[11:4], e[3:0]); end
        end
      end
    end
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      cycle(1'b0, 8'h00, 8'h00, 1'b1, acc, got, y, f);
      if (got) begin
        n_checks++;
        e = exp_q.pop_front();
        if ({y, f} !== e) begin n_fail++; $display("FAIL rand_drain: got y=%h f=%b want y=%h f=%b", y, f, e[11:4], e[3:0]); end
      end
      n++;
    end
    n_checks++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL rand_lost: %0d results missing, want 0", exp_q.size()); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] oa [4];
    logic [7:0] ob [4];
    logic acc, got;
    logic [7:0] y, held_y;
    logic [3:0] f;
    logic [11:0] e;
    int i, ii, nout, s;
    int got_at [4];
    for (int k = 0; k < 4; k++) begin
      oa[k] = {1'($urandom), 4'($urandom_range(4, 10)), 3'($urandom)};
      ob[k] = {1'($urandom), 4'($urandom_range(4, 10)), 3'($urandom)};
    end
    exp_q.delete();
    i = 0; nout = 0; s = 0; held_y = '0;
    while (nout < 4 && s < 40) begin
      ii = (i < 4) ? i : 3;
      cycle(i < 4, oa[ii], ob[ii], !(s >= 2 && s < 7), acc, got, y, f);
      if (acc) i++;
      if (s >= 3 && s < 7) begin
        n_checks++;
        if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready: step %0d got %b want 0", s, bus.in_ready); end
        n_checks++;
        if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL stall_out_valid: step %0d got %b want 1", s, bus.out_valid); end
      end
      if (s == 3) held_y = y;
      else if (s > 3 && s < 7) begin
        n_checks++;
        if (y !== held_y) begin n_fail++; $display("FAIL stall_hold: step %0d got %h want %h", s, y, held_y); end
      end
      if (got) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL b2b_extra: unexpected result %h", y);
        end else begin
          e = exp_q.pop_front();
          if ({y, f} !== e) begin n_fail++; $display("FAIL b2b_order: got y=%h f=%b want y=%h f=%b", y, f, e[11:4], e[3:0]); end
        end
        got_at[nout] = s;
        nout++;
      end
      s++;
    end
    n_checks++;
    if (nout != 4) begin
      n_fail++; $display("FAIL b2b_count: got %0d results want 4", nout);
    end else begin
      n_checks++;
      if (got_at[3] - got_at[0] != 3) begin n_fail++; $display("FAIL b2b_consecutive: span %0d want 3", got_at[3] - got_at[0]); end
    end
  endtask

  task automatic test_reset_in_flight();
    logic acc, got;
    logic [7:0] y;
    logic [3:0] f;
    int stale;
    exp_q.delete();
    cycle(1'b1, 8'h40, 8'h40, 1'b1, acc, got, y, f);
    cycle(1'b1, 8'h41, 8'h3A, 1'b1, acc, got, y, f);
    @(negedge clock);
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_flight_valid: got %b want 0", bus.out_valid); end
    @(negedge clock);
    rst_n = 1'b1;
    exp_q.delete();
    stale = 0;
    for (int k = 0; k < 8; k++) begin
      cycle(1'b0, 8'h00, 8'h00, 1'b1, acc, got, y, f);
      if (got) stale++;
    end
    n_checks++;
    if (stale != 0) begin n_fail++; $display("FAIL rst_flight_stale: got %0d results want 0", stale); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_in_flight();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
